// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Turns a CPU control-signal bundle plus a 5-bit operand back into
//            an 8-bit instruction word {opcode[2:0], operand[4:0]}. It queues
//            the words in a small FIFO and writes them to program memory
//            through a port whose address counts up on its own.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2)
//   ADDR_W - program-memory address width
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   in_valid / in_ready   - input handshake
//   bez, ja, op1, op2,
//   write_reg, writex8,
//   x8_sel[1:0]           - control bundle to re-encode
//   operand[4:0]          - immediate/register/target field, passed through
//   mem_we / mem_ready    - program-memory write handshake
//   mem_addr[ADDR_W-1:0]  - write address, wraps silently
//   mem_wdata[7:0]        - FIFO head (0 when empty)
//   addr_clr              - synchronous write-address clear
//   level                 - FIFO occupancy
//   err                   - sticky illegal-bundle flag
// Build option:
//   INSTR_ENC_ILLEGAL_CHECK_EN - when defined, illegal bundles are accepted
//   but dropped, and err is raised. When undefined, illegal bundles are
//   encoded as nop with their operand, and err stays at 0.
// ============================================================================
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     bez,
  input  logic                     ja,
  input  logic                     op1,
  input  logic                     op2,
  input  logic                     write_reg,
  input  logic                     writex8,
  input  logic [1:0]               x8_sel,
  input  logic [4:0]               operand,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     addr_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_lvl_w = c_ptr_w + 1;

  // Bundle packed in order {bez, ja, op1, op2, write_reg, writex8, x8_sel}.
  localparam logic [7:0] c_b_li  = 8'b0000_0101;
  localparam logic [7:0] c_b_add = 8'b0010_0110;
  localparam logic [7:0] c_b_bez = 8'b1001_0000;
  localparam logic [7:0] c_b_lr  = 8'b0000_0100;
  localparam logic [7:0] c_b_nop = 8'b0000_0000;
  localparam logic [7:0] c_b_sr  = 8'b0000_1000;
  localparam logic [7:0] c_b_ja  = 8'b0111_0000;
  localparam logic [7:0] c_b_not = 8'b0010_0111;

  localparam logic [2:0] c_op_nop = 3'b100;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]         fifo_q [DEPTH];
  logic [7:0]         fifo_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_lvl_w-1:0] level_q, level_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [7:0] w_bundle;
  logic [2:0] w_opcode;
  logic       w_push;
  logic       w_pop;
  logic       w_store;

  assign w_bundle = {bez, ja, op1, op2, write_reg, writex8, x8_sel};

  // Any bundle that matches no entry falls through to the nop opcode.
  always_comb begin
    w_opcode = c_op_nop;
    case (w_bundle)
      c_b_li:  w_opcode = 3'b000;
      c_b_add: w_opcode = 3'b001;
      c_b_bez: w_opcode = 3'b010;
      c_b_lr:  w_opcode = 3'b011;
      c_b_nop: w_opcode = 3'b100;
      c_b_sr:  w_opcode = 3'b101;
      c_b_ja:  w_opcode = 3'b110;
      c_b_not: w_opcode = 3'b111;
      default: w_opcode = c_op_nop;
    endcase
  end

  // in_ready depends only on the level register, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign in_ready = (level_q != c_lvl_w'(DEPTH));
  assign mem_we   = (level_q != '0);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = mem_we && mem_ready;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  logic w_legal;
  logic err_q, err_d;

  // Only the all-zero bundle legitimately produces the nop opcode; any other
  // bundle that decodes to nop did not match the table.
  assign w_legal = (w_opcode != c_op_nop) || (w_bundle == c_b_nop);
  assign w_store = w_push && w_legal;

  always_comb begin
    err_d = err_q;
    if (w_push && !w_legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign w_store = w_push;
  assign err     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;

    if (w_store) begin
      fifo_d[wr_ptr_q] = {w_opcode, operand};
      wr_ptr_d         = wr_ptr_q + c_ptr_w'(1);
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end

    case ({w_store, w_pop})
      2'b10:   level_d = level_q + c_lvl_w'(1);
      2'b01:   level_d = level_q - c_lvl_w'(1);
      default: level_d = level_q;
    endcase

    // Clearing wins over the increment of a write completing in this cycle.
    if (addr_clr) begin
      addr_d = '0;
    end else if (w_pop) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks its contents on mem_wdata.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign level     = level_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder. A driver applies directed
//            and random stimulus, predicts handshake/level/address behaviour
//            from a queue-based model and pushes expected words into a
//            scoreboard; a monitor pops and compares words as the DUT writes
//            them to program memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              bez = 1'b0, ja = 1'b0, op1 = 1'b0, op2 = 1'b0;
  logic              write_reg = 1'b0, writex8 = 1'b0;
  logic [1:0]        x8_sel = 2'd0;
  logic [4:0]        operand = 5'd0;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              addr_clr = 1'b0;
  logic [2:0]        level;
  logic              err;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bez(bez), .ja(ja), .op1(op1), .op2(op2), .write_reg(write_reg),
    .writex8(writex8), .x8_sel(x8_sel), .operand(operand),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .addr_clr(addr_clr), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Encoding table from the instruction set: index = opcode,
  // entry = {bez, ja, op1, op2, write_reg, writex8, x8_sel}.
  logic [7:0] tab [8];

  // Reference model state.
  logic [7:0]        sb[$];      // words already inside the DUT FIFO
  int                m_lvl;
  logic [ADDR_W-1:0] m_addr;
  bit                m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [7:0] b, output bit legal, output logic [2:0] opc);
    legal = 1'b0;
    opc   = 3'b100;
    for (int i = 0; i < 8; i++) begin
      if (tab[i] == b) begin
        legal = 1'b1;
        opc   = 3'(i);
      end
    end
  endtask

  // Called at posedge+1: applies inputs, advances one edge, updates the model
  // and checks the control-side outputs.
  task automatic step(input bit iv, input logic [7:0] b, input logic [4:0] opnd,
                      input bit mr, input bit clr);
    bit         push, pop, legal, store;
    logic [2:0] opc;
    in_valid  = iv;
    {bez, ja, op1, op2, write_reg, writex8, x8_sel} = b;
    operand   = opnd;
    mem_ready = mr;
    addr_clr  = clr;
    push  = iv && (m_lvl != DEPTH);
    pop   = (m_lvl != 0) && mr;
    lookup(b, legal, opc);
    store = push && (legal || !CHECK);
    @(posedge clk);
    #1;
    if (store) sb.push_back({opc, opnd});
    if (push && !legal && CHECK) m_err = 1'b1;
    m_lvl  = m_lvl + int'(store) - int'(pop);
    if (clr)      m_addr = '0;
    else if (pop) m_addr = m_addr + 1'b1;
    chk("level",    32'(level),    32'(m_lvl));
    chk("in_ready", 32'(in_ready), 32'(m_lvl != DEPTH));
    chk("mem_we",   32'(mem_we),   32'(m_lvl != 0));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("err",      32'(err),      32'(m_err));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear with no edge.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    addr_clr  = 1'b0;
    #1;
    sb.delete();
    m_lvl  = 0;
    m_addr = '0;
    m_err  = 1'b0;
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err",       32'(err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_bundle();
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return tab[$urandom_range(0, 7)];
  endfunction

  // Monitor: every word the DUT presents must be the oldest expected one;
  // a completing write retires it.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wdata: got 0x%0h expected no word at %0t", mem_wdata, $time);
      end else begin
        if (mem_wdata !== sb[0]) begin
          n_fail++;
          $display("FAIL wdata: got 0x%0h expected 0x%0h at %0t", mem_wdata, sb[0], $time);
        end
        if (mem_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] t;
    tab[0] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1}; // li
    tab[1] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}; // add
    tab[2] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // bez
    tab[3] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}; // lr
    tab[4] = 8'h00;                                      // nop
    tab[5] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // sr
    tab[6] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}; // ja
    tab[7] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3}; // not
    m_lvl = 0; m_addr = '0; m_err = 1'b0;

    do_reset();

    // li/7 then drain: word 0x07 at address 0, address then 1.
    step(1, tab[0], 5'h07, 1, 0);
    step(0, 8'h00, 5'h00, 1, 0);
    chk("li_addr_after", 32'(mem_addr), 32'd1);

    // Fill with memory stalled, then drain in order.
    do_reset();
    step(1, tab[1], 5'd3, 0, 0);
    step(1, tab[2], 5'd1, 0, 0);
    step(1, tab[5], 5'd2, 0, 0);
    step(1, tab[7], 5'd0, 0, 0);
    chk("full_level",   32'(level),    32'd4);
    chk("full_ready",   32'(in_ready), 32'd0);
    chk("full_head",    32'(mem_wdata), 32'h23);
    // Fifth word offered while full and popping: accepted one cycle later.
    step(1, tab[6], 5'd9, 1, 0);
    step(1, tab[6], 5'd9, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 5'd0, 1, 0);

    // 33 writes wrap the address; then clear coinciding with write at 9.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      t = rand_bundle();
      step(1, t, 5'($urandom), 1, 0);
    end
    for (int i = 0; i < 40 && m_addr != 5'd9; i++) step(1, tab[3], 5'($urandom), 1, 0);
    chk("pre_clr_addr", 32'(mem_addr), 32'd9);
    step(1, tab[3], 5'd4, 1, 1);
    chk("clr_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 5'd0, 1, 0);

    // Illegal bundle.
    step(1, 8'b1100_0000, 5'h15, 0, 0);
    chk("illegal_err", 32'(err), 32'(CHECK));
    step(0, 8'h00, 5'd0, 1, 0);
    step(0, 8'h00, 5'd0, 1, 0);

    // Asynchronous reset mid-drain with three words queued.
    step(1, tab[0], 5'd1, 1, 0);
    step(1, tab[0], 5'd2, 0, 0);
    step(1, tab[0], 5'd3, 0, 0);
    step(0, 8'h00, 5'd0, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      t = rand_bundle();
      step($urandom_range(0, 3) != 0, t, 5'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 5'd0, 1, 0);
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
